reaction_lane_game: RTL and testbench

Parametrised game core for the button/LED reaction game: it lights one of `N_LANES` LEDs at a time, scores correct button presses, and counts down a game timer on an external 100 ms tick. It replaces the fixed three-LED scoring block and the stand-alone countdown timer. It sits between the button shapers and game controller (single-cycle `btn` pulses, `start`), the LFSR tick source and random-number generator (`tick`, `rand_in`), and the split/seven-segment display path (`score`, `time_left`).

---
 rtl/reaction_lane_game.sv | 175 +++++++++++++++++
 tb/tb_reaction_lane_game.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_lane_game.sv
// reaction_lane_game: lane LED reaction game core.
// One lane LED is lit at a time; a press on the lit lane scores a point, and a
// game timer counts down on an external tick.
// Optional feature: define RLG_PENALTY_EN to subtract a point for each
// wrong-lane press while a target is lit.
module reaction_lane_game #(
    parameter int N_LANES   = 3,
    parameter int SCORE_MAX = 99,
    parameter int GAME_TIME = 60,
    parameter int GAP_TICKS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick,
    input  logic [1:0]         speed,
    input  logic [N_LANES-1:0] btn,
    input  logic [7:0]         rand_in,
    output logic [N_LANES-1:0] led,
    output logic [6:0]         score,
    output logic [6:0]         time_left,
    output logic               busy,
    output logic               done
);

    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int GW = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {IDLE, GAP, LIT, DONE} state_t;

    state_t             state, state_nxt;
    logic [N_LANES-1:0] led_nxt;
    logic [6:0]         score_nxt, time_nxt;
    logic [3:0]         dwell, dwell_nxt;
    logic [3:0]         dwell_cnt, dwell_cnt_nxt;
    logic [GW-1:0]      gap_cnt, gap_cnt_nxt;
    logic [LW-1:0]      prev_lane, prev_lane_nxt;
    logic               prev_valid, prev_valid_nxt;
    logic [LW-1:0]      cand, lane_pick;
    logic [3:0]         dwell_sel;
    logic               hit, wrong;

    // Pick the next lane from rand_in, stepping past the previous lane so a
    // lane never lights twice in a row.
    always_comb begin
        cand      = LW'(rand_in % 8'(N_LANES));
        lane_pick = cand;
        if (prev_valid && (cand == prev_lane))
            lane_pick = (cand == LW'(N_LANES - 1)) ? '0 : cand + 1'b1;
    end

    // Decode the dwell length chosen at start.
    always_comb begin
        case (speed)
            2'b00:   dwell_sel = 4'd10;
            2'b01:   dwell_sel = 4'd7;
            2'b10:   dwell_sel = 4'd5;
            default: dwell_sel = 4'd3;
        endcase
    end

    // Classify the button pulse against the lit lane.
    always_comb begin
`ifdef RLG_PENALTY_EN
        // Only a press of exactly the lit lane counts; anything else costs a point.
        hit   = (state == LIT) && (btn == led);
        wrong = (state == LIT) && (btn != '0) && (btn != led);
`else
        hit   = (state == LIT) && |(btn & led);
        wrong = 1'b0;
`endif
    end

    // Next-state and datapath update; the timer end overrides any lane change.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt      = state;
        led_nxt        = led;
        score_nxt      = score;
        time_nxt       = time_left;
        dwell_nxt      = dwell;
        dwell_cnt_nxt  = dwell_cnt;
        gap_cnt_nxt    = gap_cnt;
        prev_lane_nxt  = prev_lane;
        prev_valid_nxt = prev_valid;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    score_nxt      = '0;
                    time_nxt       = 7'(GAME_TIME);
                    dwell_nxt      = dwell_sel;
                    gap_cnt_nxt    = GW'(GAP_TICKS);
                    prev_valid_nxt = 1'b0;
                    led_nxt        = '0;
                    state_nxt      = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                    if (gap_cnt == GW'(1)) begin
                        led_nxt        = {{(N_LANES-1){1'b0}}, 1'b1} << lane_pick;
                        prev_lane_nxt  = lane_pick;
                        prev_valid_nxt = 1'b1;
                        dwell_cnt_nxt  = '0;
                        state_nxt      = LIT;
                    end
                end
            end
            LIT: begin
                if (hit) begin
                    if (score < 7'(SCORE_MAX))
                        score_nxt = score + 1'b1;
                    led_nxt     = '0;
                    gap_cnt_nxt = GW'(GAP_TICKS);
                    state_nxt   = GAP;
                end else begin
                    if (wrong && (score != '0))
                        score_nxt = score - 1'b1;
                    if (tick) begin
                        dwell_cnt_nxt = dwell_cnt + 1'b1;
                        if ((dwell_cnt + 1'b1) == dwell) begin
                            led_nxt     = '0;
                            gap_cnt_nxt = GW'(GAP_TICKS);
                            state_nxt   = GAP;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (((state == GAP) || (state == LIT)) && tick) begin
            if (time_left != '0)
                time_nxt = time_left - 1'b1;
            if (time_left <= 7'd1) begin
                led_nxt   = '0;
                state_nxt = DONE;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            led        <= '0;
            score      <= '0;
            time_left  <= '0;
            dwell      <= 4'd10;
            dwell_cnt  <= '0;
            gap_cnt    <= '0;
            prev_lane  <= '0;
            prev_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state      <= state_nxt;
            led        <= led_nxt;
            score      <= score_nxt;
            time_left  <= time_nxt;
            dwell      <= dwell_nxt;
            dwell_cnt  <= dwell_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            prev_lane  <= prev_lane_nxt;
            prev_valid <= prev_valid_nxt;
        end
    end

    assign busy = (state == GAP) || (state == LIT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_reaction_lane_game.sv
// Testbench for reaction_lane_game: vector table, directed corner sequences and
// randomized play against a lane/score/timer model. A second instance with a
// ceiling of 3 exercises score saturation. Honors RLG_PENALTY_EN.
module tb_reaction_lane_game;

    localparam int NL    = 3;
    localparam int GTIME = 60;
    localparam int GAPT  = 1;
    localparam int SMAX  = 99;
    localparam int SSAT  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, tick;
    logic [1:0]    speed;
    logic [NL-1:0] btn;
    logic [7:0]    rand_in;
    logic [NL-1:0] led, s_led;
    logic [6:0]    score, time_left, s_score, s_time_left;
    logic          busy, done, s_busy, s_done;

    int checks = 0;
    int errors = 0;

    reaction_lane_game #(.N_LANES(NL), .SCORE_MAX(SMAX), .GAME_TIME(GTIME), .GAP_TICKS(GAPT)) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .speed(speed), .btn(btn),
        .rand_in(rand_in), .led(led), .score(score), .time_left(time_left),
        .busy(busy), .done(done)
    );

    reaction_lane_game #(.N_LANES(NL), .SCORE_MAX(SSAT), .GAME_TIME(GTIME), .GAP_TICKS(GAPT)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .speed(speed), .btn(btn),
        .rand_in(rand_in), .led(s_led), .score(s_score), .time_left(s_time_left),
        .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int m_lane, m_prev, m_score, m_score_sat, m_time, m_dwell, m_elapsed, m_gap;
    bit m_running, m_over;
    int dwell_of[4] = '{10, 7, 5, 3};

    function automatic int lane_mask(input int l);
        return (l < 0) ? 0 : (1 << l);
    endfunction

    task automatic model_reset();
        m_lane = -1; m_prev = -1; m_score = 0; m_score_sat = 0; m_time = 0;
        m_dwell = 10; m_elapsed = 0; m_gap = 0; m_running = 0; m_over = 0;
    endtask

    task automatic model_update(input logic s, input logic t, input logic [1:0] sp,
                                input logic [NL-1:0] b, input logic [7:0] r);
        bit was_lit, hit, wrong;
        int c;
        if (!m_running) begin
            if (s) begin
                m_score = 0; m_score_sat = 0; m_time = GTIME; m_dwell = dwell_of[sp];
                m_gap = GAPT; m_prev = -1; m_lane = -1; m_running = 1; m_over = 0;
            end
            return;
        end
        was_lit = (m_lane >= 0);
        hit = 0; wrong = 0;
        if (was_lit) begin
`ifdef RLG_PENALTY_EN
            hit   = (int'(b) == lane_mask(m_lane));
            wrong = (b != 0) && !hit;
`else
            hit   = b[m_lane];
`endif
        end
        if (hit) begin
            m_score     = (m_score < SMAX) ? m_score + 1 : SMAX;
            m_score_sat = (m_score_sat < SSAT) ? m_score_sat + 1 : SSAT;
            m_lane = -1;
            m_gap  = GAPT;
        end else if (wrong) begin
            m_score     = (m_score > 0) ? m_score - 1 : 0;
            m_score_sat = (m_score_sat > 0) ? m_score_sat - 1 : 0;
        end
        if (t) begin
            if (was_lit && !hit) begin
                m_elapsed++;
                if (m_elapsed == m_dwell) begin
                    m_lane = -1;
                    m_gap  = GAPT;
                end
            end else if (!was_lit) begin
                m_gap--;
                if (m_gap == 0) begin
                    c = int'(r) % NL;
                    if (c == m_prev) c = (c + 1) % NL;
                    m_lane = c; m_prev = c; m_elapsed = 0;
                end
            end
            m_time--;
            if (m_time == 0) begin
                m_running = 0; m_over = 1; m_lane = -1;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("led", int'(led), lane_mask(m_lane));
        check("score", int'(score), m_score);
        check("time_left", int'(time_left), m_time);
        check("busy", int'(busy), int'(m_running));
        check("done", int'(done), int'(m_over));
        check("sat_led", int'(s_led), lane_mask(m_lane));
        check("sat_score", int'(s_score), m_score_sat);
        check("sat_time_left", int'(s_time_left), m_time);
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare at negedge.
    task automatic step(input logic s, input logic t, input logic [1:0] sp,
                        input logic [NL-1:0] b, input logic [7:0] r);
        start = s; tick = t; speed = sp; btn = b; rand_in = r;
        @(posedge clk);
        model_update(s, t, sp, b, r);
        @(negedge clk);
        start = 1'b0; tick = 1'b0; btn = '0;
        compare_all();
    endtask

    typedef struct {
        logic          s;
        logic          t;
        logic [1:0]    sp;
        logic [NL-1:0] b;
        logic [7:0]    r;
        logic [NL-1:0] e_led;
        int            e_score;
        int            e_time;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t vecs[14];
    int   saved;

    initial begin
        rst = 1'b0; start = 1'b0; tick = 1'b0; speed = 2'b00; btn = '0; rand_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_led", int'(led), 0);
        check("reset_score", int'(score), 0);
        check("reset_time", int'(time_left), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b1;

        // ---- table: start, ignored restart, hit, lane avoidance, 3-tick miss ----
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 3'b000, 8'd0, 3'b000, 0, 0,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 3'b001, 8'd0, 3'b000, 0, 0,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'b11, 3'b000, 8'd0, 3'b000, 0, 60, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'b00, 3'b000, 8'd0, 3'b000, 0, 60, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'b00, 3'b000, 8'd4, 3'b010, 0, 59, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 3'b100, 8'd0, 3'b010, 0, 59, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 3'b010, 8'd0, 3'b000, 1, 59, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 3'b000, 8'd7, 3'b100, 1, 58, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 3'b000, 8'd7, 3'b100, 1, 57, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 3'b000, 8'd7, 3'b100, 1, 56, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 3'b000, 8'd7, 3'b000, 1, 55, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 3'b000, 8'd2, 3'b001, 1, 54, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'b00, 3'b001, 8'd0, 3'b000, 2, 53, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'b00, 3'b000, 8'd0, 3'b010, 2, 52, 1'b1, 1'b0};
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].s, vecs[i].t, vecs[i].sp, vecs[i].b, vecs[i].r);
            check($sformatf("vec%0d_led", i), int'(led), int'(vecs[i].e_led));
            check($sformatf("vec%0d_score", i), int'(score), vecs[i].e_score);
            check($sformatf("vec%0d_time", i), int'(time_left), vecs[i].e_time);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
        end

        // ---- run the timer out; btn after the end is ignored; restart ----
        while (m_time > 1) step(1'b0, 1'b1, 2'b00, '0, 8'($urandom));
        check("pre_end_time", int'(time_left), 1);
        check("pre_end_busy", int'(busy), 1);
        step(1'b0, 1'b1, 2'b00, '0, 8'($urandom));
        check("end_done", int'(done), 1);
        check("end_busy", int'(busy), 0);
        check("end_led", int'(led), 0);
        check("end_time", int'(time_left), 0);
        saved = int'(score);
        step(1'b0, 1'b1, 2'b00, 3'b111, 8'd0);
        check("after_end_btn_score", int'(score), saved);
        check("after_end_time", int'(time_left), 0);
        step(1'b1, 1'b0, 2'b00, '0, 8'd0);
        check("restart_score", int'(score), 0);
        check("restart_time", int'(time_left), GTIME);
        check("restart_done", int'(done), 0);

        // ---- five consecutive hits; the SCORE_MAX=3 copy saturates ----
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 2'b00, '0, 8'($urandom));
            check("hit_target_lit", int'(led != 0), 1);
            step(1'b0, 1'b0, 2'b00, NL'(lane_mask(m_lane)), 8'd0);
            check("hit_led_cleared", int'(led), 0);
        end
        check("five_hits_score", int'(score), 5);
        check("sat_score_ceiling", int'(s_score), 3);
        check("five_hits_time", int'(time_left), GTIME - 5);

        // ---- asynchronous reset while a target is lit ----
        step(1'b0, 1'b1, 2'b00, '0, 8'($urandom));
        check("pre_reset_lit", int'(led != 0), 1);
        #2 rst = 1'b0;
        #1;
        check("async_led", int'(led), 0);
        check("async_score", int'(score), 0);
        check("async_time", int'(time_left), 0);
        check("async_busy", int'(busy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b1, 2'b00, 3'b111, 8'($urandom));
        check("no_resume_busy", int'(busy), 0);

        // ---- wrong-lane presses from a score of 2 ----
        step(1'b1, 1'b0, 2'b00, '0, 8'd0);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 2'b00, '0, 8'($urandom));
            step(1'b0, 1'b0, 2'b00, NL'(lane_mask(m_lane)), 8'd0);
        end
        check("pre_penalty_score", int'(score), 2);
        step(1'b0, 1'b1, 2'b00, '0, 8'($urandom));
        saved = int'(led);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 2'b00, NL'(lane_mask((m_lane + 1) % NL)), 8'd0);
`ifdef RLG_PENALTY_EN
            check($sformatf("penalty_score%0d", k), int'(score), (k == 0) ? 1 : 0);
`else
            check($sformatf("wrong_lane_score%0d", k), int'(score), 2);
`endif
            check($sformatf("wrong_lane_led%0d", k), int'(led), saved);
        end

        // ---- hit on the same edge as the final tick ----
        while (m_time > 1) begin
            if (m_lane >= 0) step(1'b0, 1'b0, 2'b00, NL'(lane_mask(m_lane)), 8'd0);
            step(1'b0, 1'b1, 2'b00, '0, 8'($urandom));
        end
        check("final_tick_target_lit", int'(led != 0), 1);
        saved = int'(score);
        step(1'b0, 1'b1, 2'b00, NL'(lane_mask(m_lane)), 8'($urandom));
        check("final_tick_hit_score", int'(score), saved + 1);
        check("final_tick_done", int'(done), 1);
        check("final_tick_led", int'(led), 0);

        // ---- randomized play ----
        for (int i = 0; i < 3000; i++) begin
            logic          rs, rt;
            logic [NL-1:0] rb;
            rs = ($urandom_range(0, 19) == 0);
            rt = ($urandom_range(0, 3) == 0);
            rb = '0;
            if (m_lane >= 0 && $urandom_range(0, 5) == 0) rb = NL'(lane_mask(m_lane));
            else if ($urandom_range(0, 4) == 0) rb = NL'($urandom);
            step(rs, rt, 2'($urandom), rb, (i % 200 < 40) ? 8'd5 : 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
